// File: rtl/fir8_14b_if.sv
// Sample-stream and coefficient bundle for the 9-tap FIR filter.
// The master drives samples and coefficients; the slave (the filter) returns the filtered output.
interface fir8_14b_if;
  logic               ce;
  logic signed [31:0] is32_coeff_0;
  logic signed [31:0] is32_coeff_1;
  logic signed [31:0] is32_coeff_2;
  logic signed [31:0] is32_coeff_3;
  logic signed [31:0] is32_coeff_4;
  logic signed [31:0] is32_coeff_5;
  logic signed [31:0] is32_coeff_6;
  logic signed [31:0] is32_coeff_7;
  logic signed [31:0] is32_coeff_8;
  logic signed [13:0] is14_in;
  logic signed [13:0] os14_out;

  modport master (
    output ce, is32_coeff_0, is32_coeff_1, is32_coeff_2, is32_coeff_3, is32_coeff_4,
           is32_coeff_5, is32_coeff_6, is32_coeff_7, is32_coeff_8, is14_in,
    input  os14_out
  );

  modport slave (
    input  ce, is32_coeff_0, is32_coeff_1, is32_coeff_2, is32_coeff_3, is32_coeff_4,
           is32_coeff_5, is32_coeff_6, is32_coeff_7, is32_coeff_8, is14_in,
    output os14_out
  );
endinterface

// File: rtl/fir8_14b.sv
// 9-tap direct-form FIR on 14-bit signed samples with Q1.31 coefficients.
// The delay line shifts on ce; the saturated output is registered one clock later.
module fir8_14b (
  input  logic      clk,
  input  logic      rst,
  fir8_14b_if.slave bus
);
  localparam int NTAPS = 9;
  localparam logic signed [49:0] SAT_MAX = 50'sd8191;
  localparam logic signed [49:0] SAT_MIN = -50'sd8192;

  logic signed [13:0] x_q   [NTAPS];
  logic signed [13:0] x_d   [NTAPS];
  logic               valid_q, valid_d;
  logic signed [13:0] out_q, out_d;

  logic signed [31:0] coeff [NTAPS];
  logic signed [45:0] prod  [NTAPS];
  logic signed [49:0] sum;
  logic signed [49:0] scaled;

  assign coeff[0] = bus.is32_coeff_0;
  assign coeff[1] = bus.is32_coeff_1;
  assign coeff[2] = bus.is32_coeff_2;
  assign coeff[3] = bus.is32_coeff_3;
  assign coeff[4] = bus.is32_coeff_4;
  assign coeff[5] = bus.is32_coeff_5;
  assign coeff[6] = bus.is32_coeff_6;
  assign coeff[7] = bus.is32_coeff_7;
  assign coeff[8] = bus.is32_coeff_8;

  always_comb begin : delay_line
    // NOTE: every tap gets a hold value first so no path through this block infers a latch.
    for (int k = 0; k < NTAPS; k++) x_d[k] = x_q[k];
    if (bus.ce) begin
      x_d[0] = bus.is14_in;
      for (int k = 1; k < NTAPS; k++) x_d[k] = x_q[k-1];
    end
  end

  // Nine 46-bit products summed in 50 bits can never overflow (|sum| < 2^48).
  always_comb begin : mac
    sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      prod[k] = $signed({{32{x_q[k][13]}}, x_q[k]}) * $signed({{14{coeff[k][31]}}, coeff[k]});
      sum     = sum + {{4{prod[k][45]}}, prod[k]};
    end
    scaled = sum >>> 31;
  end

  always_comb begin : out_stage
    valid_d = bus.ce;
    out_d   = out_q;
    if (valid_q) begin
      if (scaled > SAT_MAX)      out_d = 14'h1FFF;
      else if (scaled < SAT_MIN) out_d = 14'h2000;
      else                       out_d = scaled[13:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the delay line is a register array, not RAM, so it is cleared on reset to restart from zero history.
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every tap samples its neighbour's pre-edge value.
      x_q     <= x_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign bus.os14_out = out_q;
endmodule

// File: tb/tb_fir8_14b.sv
// Self-checking bench for fir8_14b: directed spec scenarios plus randomized streams
// compared against an arithmetic reference model of the filter.
module tb_fir8_14b;
  logic clk = 1'b0;
  logic rst;
  logic signed [31:0] cf [9];
  int   hist [9];
  int   exp_out;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir8_14b_if bus ();

  fir8_14b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.is32_coeff_0 = cf[0];
  assign bus.is32_coeff_1 = cf[1];
  assign bus.is32_coeff_2 = cf[2];
  assign bus.is32_coeff_3 = cf[3];
  assign bus.is32_coeff_4 = cf[4];
  assign bus.is32_coeff_5 = cf[5];
  assign bus.is32_coeff_6 = cf[6];
  assign bus.is32_coeff_7 = cf[7];
  assign bus.is32_coeff_8 = cf[8];

  // Reference model: history of the last nine samples, newest first.
  function automatic void model_reset();
    for (int k = 0; k < 9; k++) hist[k] = 0;
    exp_out = 0;
  endfunction

  function automatic void model_shift(input int x);
    for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endfunction

  function automatic int model_out();
    longint acc = 0;
    for (int k = 0; k < 9; k++) acc += longint'(hist[k]) * longint'(cf[k]);
    acc = acc >>> 31;
    if (acc > 8191)  return 8191;
    if (acc < -8192) return -8192;
    return int'(acc);
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic set_all_coeffs(input logic signed [31:0] c);
    for (int k = 0; k < 9; k++) cf[k] = c;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ce = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One ce pulse; returns at the negedge after the shift edge (output not yet updated).
  task automatic push(input int x);
    @(negedge clk);
    bus.is14_in = 14'(x);
    bus.ce = 1'b1;
    @(negedge clk);
    bus.ce = 1'b0;
    model_shift(x);
    exp_out = model_out();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ce = 1'b0;
    bus.is14_in = 14'sd3000;
    set_all_coeffs(32'sd238609294);
    repeat (2) @(negedge clk);
    checks++;
    if (int'(bus.os14_out) !== 0) begin
      errors++;
      $display("FAIL reset_hold: got %0d want 0", bus.os14_out);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (int'(bus.os14_out) !== 0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %0d want 0", i, bus.os14_out);
      end
    end
  endtask

  task automatic test_step();
    int tab [9] = '{333, 666, 999, 1333, 1666, 1999, 2333, 2666, 2999};
    int prev = 0;
    int want;
    apply_reset();
    set_all_coeffs(32'sd238609294);
    for (int i = 0; i < 11; i++) begin
      push(3000);
      checks++;
      if (int'(bus.os14_out) !== prev) begin
        errors++;
        $display("FAIL step_latency[%0d]: got %0d want %0d", i, bus.os14_out, prev);
      end
      @(negedge clk);
      want = tab[(i < 9) ? i : 8];
      checks++;
      if (int'(bus.os14_out) !== want) begin
        errors++;
        $display("FAIL step[%0d]: got %0d want %0d", i, bus.os14_out, want);
      end
      prev = want;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_impulse();
    int tab [10] = '{63, 127, 191, 255, 319, 383, 447, 511, 575, 0};
    apply_reset();
    for (int k = 0; k < 9; k++) cf[k] = 32'((k + 1) << 24);
    for (int i = 0; i < 10; i++) begin
      push((i == 0) ? 8191 : 0);
      @(negedge clk);
      checks++;
      if (int'(bus.os14_out) !== tab[i]) begin
        errors++;
        $display("FAIL impulse[%0d]: got %0d want %0d", i, bus.os14_out, tab[i]);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    set_all_coeffs(32'sh7FFFFFFF);
    for (int i = 0; i < 18; i++) begin
      push((i < 9) ? 8191 : -8192);
      @(negedge clk);
      checks++;
      if (int'(bus.os14_out) !== exp_out) begin
        errors++;
        $display("FAIL sat_model[%0d]: got %0d want %0d", i, bus.os14_out, exp_out);
      end
      if (i == 8 || i == 17) begin
        checks++;
        if (int'(bus.os14_out) !== ((i == 8) ? 8191 : -8192)) begin
          errors++;
          $display("FAIL sat_clamp[%0d]: got %0d want %0d", i, bus.os14_out, (i == 8) ? 8191 : -8192);
        end
      end
    end
    apply_reset();
    set_all_coeffs(32'sd0);
    cf[0] = 32'sh80000000;
    push(-8192);
    @(negedge clk);
    checks++;
    if (int'(bus.os14_out) !== 8191) begin
      errors++;
      $display("FAIL sat_neg_one: got %0d want 8191", bus.os14_out);
    end
  endtask

  task automatic test_truncation();
    apply_reset();
    set_all_coeffs(32'sd0);
    cf[0] = 32'sd1073741824;
    push(-3);
    @(negedge clk);
    checks++;
    if (int'(bus.os14_out) !== -2) begin
      errors++;
      $display("FAIL trunc_floor: got %0d want -2", bus.os14_out);
    end
  endtask

  task automatic test_back_to_back();
    int a [12];
    apply_reset();
    for (int k = 0; k < 9; k++) cf[k] = $signed($urandom()) >>> $urandom_range(2, 5);
    for (int i = 0; i < 12; i++) a[i] = rand_sample();
    @(negedge clk);
    bus.ce = 1'b1;
    bus.is14_in = 14'(a[0]);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (int'(bus.os14_out) !== exp_out) begin
          errors++;
          $display("FAIL b2b[%0d]: got %0d want %0d", i - 1, bus.os14_out, exp_out);
        end
      end
      model_shift(a[i]);
      exp_out = model_out();
      if (i < 11) bus.is14_in = 14'(a[i+1]);
      else        bus.ce = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (int'(bus.os14_out) !== exp_out) begin
      errors++;
      $display("FAIL b2b_last: got %0d want %0d", bus.os14_out, exp_out);
    end
  endtask

  task automatic test_random();
    int k;
    apply_reset();
    for (int j = 0; j < 9; j++) cf[j] = $signed($urandom()) >>> $urandom_range(1, 4);
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 9) begin
        // New coefficient must not disturb the held output until the next update.
        k = int'($urandom_range(0, 8));
        cf[k] = $signed($urandom()) >>> $urandom_range(1, 4);
        repeat (2) @(negedge clk);
        checks++;
        if (int'(bus.os14_out) !== exp_out) begin
          errors++;
          $display("FAIL coeff_change_hold[%0d]: got %0d want %0d", i, bus.os14_out, exp_out);
        end
      end
      push(rand_sample());
      @(negedge clk);
      checks++;
      if (int'(bus.os14_out) !== exp_out) begin
        errors++;
        $display("FAIL random[%0d]: got %0d want %0d", i, bus.os14_out, exp_out);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_gating_and_midreset();
    apply_reset();
    set_all_coeffs(32'sd238609294);
    repeat (3) push(3000);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.is14_in = 14'(rand_sample());
      @(negedge clk);
      checks++;
      if (int'(bus.os14_out) !== 999) begin
        errors++;
        $display("FAIL ce_gate[%0d]: got %0d want 999", i, bus.os14_out);
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (int'(bus.os14_out) !== 0) begin
      errors++;
      $display("FAIL async_reset: got %0d want 0", bus.os14_out);
    end
    @(negedge clk);
    bus.is14_in = 14'sd3000;
    bus.ce = 1'b1;
    repeat (2) @(negedge clk);
    bus.ce = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    push(3000);
    @(negedge clk);
    checks++;
    if (int'(bus.os14_out) !== 333) begin
      errors++;
      $display("FAIL restart_first: got %0d want 333", bus.os14_out);
    end
    push(3000);
    @(negedge clk);
    checks++;
    if (int'(bus.os14_out) !== 666) begin
      errors++;
      $display("FAIL restart_second: got %0d want 666", bus.os14_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.ce = 1'b0;
    bus.is14_in = '0;
    for (int k = 0; k < 9; k++) cf[k] = '0;
    model_reset();
    test_reset();
    test_step();
    test_impulse();
    test_saturation();
    test_truncation();
    test_back_to_back();
    test_random();
    test_gating_and_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
